// File: rtl/golomb_result_unloader.sv
// golomb_result_unloader: snapshots the ruler search results on done and
// streams them to the host as a framed, XOR-checksummed valid/ready byte stream.
//
// Ports:
//   FXCLK, RESET_IN_N   clock (rising edge), async active-low reset
//   done                search complete level from the mark counter assembly
//   numResults          valid result count (clamped to NUMRESULTS)
//   results             {r[1],...,r[NUMRESULTS]}, each r = {m[0],...,m[NUMPOSITIONS]}
//   tx_data/tx_valid    byte stream to host, accepted on tx_valid && tx_ready
//   tx_ready            host accept
//   busy                high from snapshot until checksum byte accepted
//   unload_done         one-cycle pulse after checksum byte accepted
module golomb_result_unloader #(
  parameter int NUMPOSITIONS = 5,
  parameter int NUMRESULTS   = 10
) (
  input  logic                                      FXCLK,
  input  logic                                      RESET_IN_N,
  input  logic                                      done,
  input  logic [5:0]                                numResults,
  input  logic [NUMRESULTS*(NUMPOSITIONS+1)*9-1:0]  results,
  output logic [7:0]                                tx_data,
  output logic                                      tx_valid,
  input  logic                                      tx_ready,
  output logic                                      busy,
  output logic                                      unload_done
);

  localparam int W  = (NUMPOSITIONS + 1) * 9;
  localparam int RW = NUMRESULTS * W;
  localparam int NM = NUMRESULTS * (NUMPOSITIONS + 1);
  localparam int SW = $clog2(NM);
  localparam int NS = 1 << SW;

  localparam logic [5:0] MAXCNT = 6'(NUMRESULTS);
  localparam logic [6:0] LASTJ  = 7'(NUMPOSITIONS);
  localparam logic [7:0] HDR_B  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CNT,
    S_MHI,
    S_MLO,
    S_CSUM
  } state_e;

  state_e          state_q, state_d;
  logic            done_q;
  logic [RW-1:0]   snap_q, snap_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      k_q, k_d;
  logic [6:0]      j_q, j_d;
  logic [7:0]      csum_q, csum_d;
  logic            unload_done_q, unload_done_d;

  logic [8:0]      mark_a [NS];
  logic [SW-1:0]   sel;
  logic [8:0]      mark;
  logic            xfer;

  // Flatten the snapshot into a mark table indexed by
  // (result-1)*(NUMPOSITIONS+1)+mark; unused tail entries read zero.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      mark_a[i] = '0;
    end
    for (int r = 0; r < NUMRESULTS; r++) begin
      for (int j = 0; j < NUMPOSITIONS + 1; j++) begin
        mark_a[r*(NUMPOSITIONS+1)+j] =
          snap_q[(NUMRESULTS-1-r)*W + W-9-9*j +: 9];
      end
    end
  end

  assign sel = SW'((int'(k_q) - 1) * (NUMPOSITIONS + 1) + int'(j_q));
  assign mark = mark_a[sel];

  // Outputs decode from registered state only, so tx_ready never
  // reaches tx_valid/tx_data combinationally.
  assign tx_valid    = (state_q != S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign unload_done = unload_done_q;
  assign xfer        = tx_valid && tx_ready;

  always_comb begin
    tx_data = 8'h00;
    unique case (state_q)
      S_HDR:   tx_data = HDR_B;
      S_CNT:   tx_data = {2'b00, cnt_q};
      S_MHI:   tx_data = {7'b0, mark[8]};
      S_MLO:   tx_data = mark[7:0];
      S_CSUM:  tx_data = csum_q;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    j_d           = j_q;
    csum_d        = csum_q;
    unload_done_d = 1'b0;

    if (state_q == S_IDLE) begin
      if (done && !done_q) begin
        snap_d  = results;
        cnt_d   = (numResults > MAXCNT) ? MAXCNT : numResults;
        csum_d  = 8'h00;
        k_d     = 6'd0;
        j_d     = 7'd0;
        state_d = S_HDR;
      end
    end else if (xfer) begin
      csum_d = csum_q ^ tx_data;
      unique case (state_q)
        S_HDR: state_d = S_CNT;
        S_CNT: begin
          if (cnt_q == 6'd0) begin
            state_d = S_CSUM;
          end else begin
            k_d     = 6'd1;
            j_d     = 7'd0;
            state_d = S_MHI;
          end
        end
        S_MHI: state_d = S_MLO;
        S_MLO: begin
          if (j_q == LASTJ) begin
            if (k_q == cnt_q) begin
              state_d = S_CSUM;
            end else begin
              k_d     = k_q + 6'd1;
              j_d     = 7'd0;
              state_d = S_MHI;
            end
          end else begin
            j_d     = j_q + 7'd1;
            state_d = S_MHI;
          end
        end
        S_CSUM: begin
          state_d       = S_IDLE;
          unload_done_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge FXCLK or negedge RESET_IN_N) begin
    if (!RESET_IN_N) begin
      state_q       <= S_IDLE;
      done_q        <= 1'b0;
      snap_q        <= '0;
      cnt_q         <= '0;
      k_q           <= '0;
      j_q           <= '0;
      csum_q        <= '0;
      unload_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= done;
      snap_q        <= snap_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      j_q           <= j_d;
      csum_q        <= csum_d;
      unload_done_q <= unload_done_d;
    end
  end

endmodule
